// File: rtl/llpm_select_rr_locked.sv
// Round-robin N:1 message select; the grant is held until the owner's tail beat transfers.
// Latency: one IDLE arbitration cycle before each message, then x->a is combinational.
// Backpressure: a_bp passes straight to the owner's x_bp; all other inputs see x_bp=1.
module llpm_select_rr_locked #(
    parameter int Width          = 8,
    parameter int NumInputs      = 4,
    parameter int CLog2NumInputs = 2,
    parameter int MaxBeats       = 16,
    parameter int CLog2MaxBeats  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [Width-1:0]          x [NumInputs],
    input  logic [NumInputs-1:0]      x_last,
    input  logic [NumInputs-1:0]      x_valid,
    output logic [NumInputs-1:0]      x_bp,
    output logic [Width-1:0]          a,
    output logic                      a_last,
    output logic                      a_valid,
    input  logic                      a_bp,
    output logic [CLog2NumInputs-1:0] grant,
    output logic                      locked,
    output logic                      overrun
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                      state_q, state_d;
    logic [CLog2NumInputs-1:0]   ptr_q, ptr_d;
    logic [CLog2NumInputs-1:0]   grant_q, grant_d;
    logic [CLog2MaxBeats-1:0]    beats_q, beats_d;
    logic                        overrun_q, overrun_d;

    logic [CLog2NumInputs-1:0]   winner;
    logic                        found;
    logic [CLog2NumInputs-1:0]   cand;
    logic                        xfer;

    // Scan starts just after the last owner, so the last owner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NumInputs; k++) begin
            cand = CLog2NumInputs'((int'(ptr_q) + k) % NumInputs);
            if (!found && x_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        a       = '0;
        a_last  = 1'b0;
        a_valid = 1'b0;
        x_bp    = '1;
        if (state_q == ST_LOCKED) begin
            a              = x[grant_q];
            a_last         = x_last[grant_q];
            a_valid        = x_valid[grant_q];
            x_bp[grant_q]  = a_bp;
        end
    end

    assign xfer = (state_q == ST_LOCKED) && x_valid[grant_q] && !a_bp;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        beats_d   = beats_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    beats_d = '0;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    if (beats_q != {CLog2MaxBeats{1'b1}}) begin
                        beats_d = beats_q + CLog2MaxBeats'(1);
                    end
                    if (x_last[grant_q]) begin
                        ptr_d   = grant_q;
                        state_d = ST_IDLE;
                    end else if ((int'(beats_q) + 1) == MaxBeats) begin
                        // Forced release: the rest of the message competes again later.
                        overrun_d = 1'b1;
                        ptr_d     = grant_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= CLog2NumInputs'(NumInputs - 1);
            grant_q   <= '0;
            beats_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            beats_q   <= beats_d;
            overrun_q <= overrun_d;
        end
    end

    assign grant   = grant_q;
    assign locked  = (state_q == ST_LOCKED);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_llpm_select_rr_locked.sv
// Directed bench for llpm_select_rr_locked: per-input message queues feed the DUT while an
// owner/beat-count model predicts every output each cycle; logged output streams pin the model.
module tb_llpm_select_rr_locked;

    localparam int NI   = 4;
    localparam int MAXB = 4;

    logic       clk;
    logic       reset;
    logic [7:0] x [NI];
    logic [3:0] x_last;
    logic [3:0] x_valid;
    logic [3:0] x_bp;
    logic [7:0] a;
    logic       a_last;
    logic       a_valid;
    logic       a_bp;
    logic [1:0] grant;
    logic       locked;
    logic       overrun;

    llpm_select_rr_locked #(
        .Width(8), .NumInputs(NI), .CLog2NumInputs(2), .MaxBeats(MAXB), .CLog2MaxBeats(3)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .x_last(x_last), .x_valid(x_valid), .x_bp(x_bp),
        .a(a), .a_last(a_last), .a_valid(a_valid), .a_bp(a_bp),
        .grant(grant), .locked(locked), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_chk;
    int         n_fail;
    int         cyc;
    logic [8:0] srcq [NI][$];
    logic [7:0] olog [$];
    int         ocyc [$];
    int         glog [$];

    // Model: who owns the output, how many beats it has sent, where the scan resumes.
    bit         m_locked;
    int         m_owner;
    int         m_ptr;
    int         m_beats;
    bit         m_overrun;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] v);
        int r;
        r = -1;
        for (int k = 1; k <= NI; k++) begin
            if (r < 0 && v[(p + k) % NI]) r = (p + k) % NI;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_locked  = 0;
        m_owner   = 0;
        m_ptr     = NI - 1;
        m_beats   = 0;
        m_overrun = 0;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        srcq[i].push_back({l, d});
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0) begin
                x_valid[i] = 1'b1;
                {x_last[i], x[i]} = srcq[i][0];
            end else begin
                x_valid[i] = 1'b0;
                x_last[i]  = 1'b0;
                x[i]       = 8'h00;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then pop and redrive.
    task automatic step();
        logic [3:0] e_bp;
        logic [7:0] e_a;
        logic       e_av;
        logic       e_last;
        logic [3:0] fire;
        @(negedge clk);
        e_bp = 4'hF; e_a = 8'h00; e_av = 1'b0; e_last = 1'b0;
        if (m_locked) begin
            e_av          = x_valid[m_owner];
            e_a           = x[m_owner];
            e_last        = x_last[m_owner];
            e_bp[m_owner] = a_bp;
        end
        chk("a_valid", {31'b0, a_valid}, {31'b0, e_av});
        chk("a_last",  {31'b0, a_last},  {31'b0, e_last});
        chk("a",       {24'b0, a},       {24'b0, e_a});
        chk("x_bp",    {28'b0, x_bp},    {28'b0, e_bp});
        chk("locked",  {31'b0, locked},  {31'b0, m_locked});
        chk("grant",   {30'b0, grant},   m_owner);
        chk("overrun", {31'b0, overrun}, {31'b0, m_overrun});
        fire = x_valid & ~x_bp;
        if (a_valid && !a_bp) begin
            olog.push_back(a);
            ocyc.push_back(cyc);
        end
        if (locked) glog.push_back(int'(grant));
        if (!reset) begin
            if (!m_locked) begin
                if (x_valid != 4'b0) begin
                    m_owner  = rr_pick(m_ptr, x_valid);
                    m_beats  = 0;
                    m_locked = 1;
                end
            end else if (x_valid[m_owner] && !a_bp) begin
                m_beats++;
                if (x_last[m_owner]) begin
                    m_ptr    = m_owner;
                    m_locked = 0;
                end else if (m_beats == MAXB) begin
                    m_overrun = 1;
                    m_ptr     = m_owner;
                    m_locked  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        drive_inputs();
        cyc++;
    endtask

    function automatic bit busy();
        bit b;
        b = m_locked || locked;
        for (int i = 0; i < NI; i++) if (srcq[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && busy()) begin
            step();
            n++;
        end
        chk("drain_done", {31'b0, busy()}, 32'd0);
    endtask

    task automatic clear_logs();
        olog.delete();
        ocyc.delete();
        glog.delete();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; a_bp = 1'b0;
        model_reset();
        drive_inputs();
        repeat (2) step();
        chk("rst_x_bp", {28'b0, x_bp}, 32'hF);
        chk("rst_locked", {31'b0, locked}, 32'd0);
        reset = 1'b0;

        // All four inputs hold single-beat messages: strict rotation from input 0.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NI; i++) push(i, 8'(8'h10 + 8'(i) + 8'(k * 16)), 1'b1);
        clear_logs();
        step();
        chk("idle_x_bp", {28'b0, x_bp}, 32'hF);
        drain(40);
        chk("t1_glog_n", glog.size(), 8);
        chk("t1_g0", glog[0], 0);
        chk("t1_g1", glog[1], 1);
        chk("t1_g2", glog[2], 2);
        chk("t1_g3", glog[3], 3);
        chk("t1_g4", glog[4], 0);
        chk("t1_d4", {24'b0, olog[4]}, 32'h20);
        chk("t1_gap", ocyc[1] - ocyc[0], 2);

        // Input 2 sends three beats; input 1 requests while it is locked.
        clear_logs();
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        step();
        push(1, 8'h1A, 1'b1);
        drain(40);
        chk("t2_n", olog.size(), 4);
        chk("t2_b0", {24'b0, olog[0]}, 32'h21);
        chk("t2_b1", {24'b0, olog[1]}, 32'h22);
        chk("t2_b2", {24'b0, olog[2]}, 32'h23);
        chk("t2_b3", {24'b0, olog[3]}, 32'h1A);

        // Output stalled for five locked cycles on input 0.
        clear_logs();
        a_bp = 1'b1;
        push(0, 8'h30, 1'b0); push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b1);
        repeat (7) step();
        chk("t3_a_held", {24'b0, a}, 32'h30);
        chk("t3_bp0", {31'b0, x_bp[0]}, 32'd1);
        chk("t3_none", olog.size(), 0);
        a_bp = 1'b0;
        drain(40);
        chk("t3_n", olog.size(), 3);
        chk("t3_b0", {24'b0, olog[0]}, 32'h30);
        chk("t3_b1", {24'b0, olog[1]}, 32'h31);
        chk("t3_b2", {24'b0, olog[2]}, 32'h32);

        // Input 3 exceeds MaxBeats; input 1 gets in before the remainder.
        clear_logs();
        for (int b = 0; b < 6; b++) push(3, 8'(8'h40 + 8'(b)), 1'b0);
        push(3, 8'h46, 1'b1);
        step();
        push(1, 8'h50, 1'b1);
        drain(60);
        chk("t4_overrun", {31'b0, overrun}, 32'd1);
        chk("t4_n", olog.size(), 8);
        chk("t4_b3", {24'b0, olog[3]}, 32'h43);
        chk("t4_b4", {24'b0, olog[4]}, 32'h50);
        chk("t4_b5", {24'b0, olog[5]}, 32'h44);
        chk("t4_b7", {24'b0, olog[7]}, 32'h46);

        // Reset lands mid-message, between clock edges.
        clear_logs();
        for (int b = 0; b < 4; b++) push(2, 8'(8'h70 + 8'(b)), (b == 3));
        for (int n = 0; n < 20 && olog.size() < 1; n++) step();
        chk("t5_first_beat", olog.size(), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_a_valid", {31'b0, a_valid}, 32'd0);
        chk("t5_x_bp", {28'b0, x_bp}, 32'hF);
        chk("t5_locked", {31'b0, locked}, 32'd0);
        chk("t5_overrun", {31'b0, overrun}, 32'd0);
        for (int i = 0; i < NI; i++) srcq[i].delete();
        model_reset();
        drive_inputs();
        repeat (2) step();
        reset = 1'b0;
        clear_logs();
        push(0, 8'h60, 1'b1);
        push(3, 8'h63, 1'b1);
        drain(40);
        chk("t5_n", olog.size(), 2);
        chk("t5_b0", {24'b0, olog[0]}, 32'h60);
        chk("t5_b1", {24'b0, olog[1]}, 32'h63);

        // Sole requester is the previous owner: regranted after one IDLE cycle.
        clear_logs();
        push(1, 8'h1B, 1'b1);
        push(1, 8'h1C, 1'b1);
        drain(40);
        chk("t6_n", olog.size(), 2);
        chk("t6_b1", {24'b0, olog[1]}, 32'h1C);
        chk("t6_gap", ocyc[1] - ocyc[0], 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
